// File: rtl/cnn_pkg.sv
// Shared definitions for the custom CNN ALU ops: ALUCtrl codes, sequencer states and
// the accumulator command set.
package cnn_pkg;

    localparam logic [3:0] ALU_ADD     = 4'b0001;
    localparam logic [3:0] ALU_SUB     = 4'b0010;
    localparam logic [3:0] ALU_AND     = 4'b0011;
    localparam logic [3:0] ALU_OR      = 4'b0100;
    localparam logic [3:0] ALU_MUL     = 4'b0110;
    localparam logic [3:0] ALU_RELU    = 4'b0111;
    localparam logic [3:0] ALU_MAXPOOL = 4'b1000;
    localparam logic [3:0] ALU_FC      = 4'b1001;

    typedef enum logic [2:0] {
        IDLE,
        REQ_A,
        WAIT_A,
        REQ_B,
        WAIT_B,
        DONE
    } seq_state_t;

    typedef enum logic [2:0] {
        ACC_HOLD,
        ACC_CLR,
        ACC_LOAD,
        ACC_MAX,
        ACC_MAC
    } acc_op_t;

    function automatic logic is_seq_op(input logic [3:0] op);
        return (op == ALU_MAXPOOL) || (op == ALU_FC);
    endfunction

endpackage

// File: rtl/cnn_acc_unit.sv
// Accumulator for the CNN sequencer: clear, load, running signed max and
// 32x32 multiply-accumulate keeping the low 32 bits.
module cnn_acc_unit
    import cnn_pkg::*;
(
    input  logic               clk_i,
    input  acc_op_t            i_op,
    input  logic signed [31:0] i_word,
    input  logic signed [31:0] i_act,
    output logic signed [31:0] o_acc
);

    logic signed [31:0] r_acc;
    logic signed [31:0] w_prod_lo;

    function automatic logic signed [31:0] max_s(input logic signed [31:0] a,
                                                 input logic signed [31:0] b);
        return (b > a) ? b : a;
    endfunction

    // Low half of the product is identical for signed and unsigned operands.
    assign w_prod_lo = i_act * i_word;

    always_ff @(posedge clk_i) begin
        unique case (i_op)
            ACC_CLR:  r_acc <= '0;
            ACC_LOAD: r_acc <= i_word;
            ACC_MAX:  r_acc <= max_s(r_acc, i_word);
            ACC_MAC:  r_acc <= r_acc + w_prod_lo;
            default:  r_acc <= r_acc;
        endcase
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/cnn_op_sequencer.sv
// Multi-cycle sequencer for the MaxPool / FC custom ops: stalls EX, streams operands from
// data memory over req/gnt/rvalid and returns one 32-bit result for write-back.
module cnn_op_sequencer
    import cnn_pkg::*;
#(
    parameter int unsigned MAX_WIN = 4,
    parameter int unsigned FC_LEN  = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [3:0]  op_i,
    input  logic [31:0] src_a_i,
    input  logic [31:0] src_b_i,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        done_o,
    output logic [31:0] result_o
);

    if (MAX_WIN < 1 || MAX_WIN > 255) begin : g_bad_max_win
        $error("MAX_WIN must be in 1..255");
    end
    if (FC_LEN < 1 || FC_LEN > 255) begin : g_bad_fc_len
        $error("FC_LEN must be in 1..255");
    end

    localparam logic [7:0] MAX_LAST = 8'(MAX_WIN - 1);
    localparam logic [7:0] FC_LAST  = 8'(FC_LEN - 1);

    seq_state_t         r_state;
    seq_state_t         w_next;
    logic [3:0]         r_op;
    logic [7:0]         r_idx;
    logic [31:0]        r_base_a;
    logic [31:0]        r_base_b;
    logic [31:0]        r_result;
    logic signed [31:0] r_act;
    logic signed [31:0] w_acc;
    acc_op_t            w_acc_op;
    logic               w_accept;
    logic               w_advance;
    logic               w_is_fc;
    logic               w_last;
    logic [31:0]        w_offset;

    assign w_is_fc  = (r_op == ALU_FC);
    assign w_last   = (r_idx == (w_is_fc ? FC_LAST : MAX_LAST));
    assign w_offset = {22'd0, r_idx, 2'b00};
    assign w_accept = (r_state == IDLE) && start_i && is_seq_op(op_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        stall_o    = 1'b0;
        mem_req_o  = 1'b0;
        mem_addr_o = '0;
        done_o     = 1'b0;
        w_acc_op   = ACC_HOLD;
        w_advance  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next   = REQ_A;
                    w_acc_op = ACC_CLR;
                end
            end
            REQ_A: begin
                stall_o    = 1'b1;
                mem_req_o  = 1'b1;
                mem_addr_o = r_base_a + w_offset;
                if (mem_gnt_i) w_next = WAIT_A;
            end
            WAIT_A: begin
                stall_o = 1'b1;
                if (mem_rvalid_i) begin
                    if (w_is_fc) begin
                        w_next = REQ_B;
                    end else begin
                        // First word of the window seeds the running max.
                        w_acc_op  = (r_idx == 8'd0) ? ACC_LOAD : ACC_MAX;
                        w_next    = w_last ? DONE : REQ_A;
                        w_advance = !w_last;
                    end
                end
            end
            REQ_B: begin
                stall_o    = 1'b1;
                mem_req_o  = 1'b1;
                mem_addr_o = r_base_b + w_offset;
                if (mem_gnt_i) w_next = WAIT_B;
            end
            WAIT_B: begin
                stall_o = 1'b1;
                if (mem_rvalid_i) begin
                    w_acc_op  = ACC_MAC;
                    w_next    = w_last ? DONE : REQ_A;
                    w_advance = !w_last;
                end
            end
            DONE: begin
                done_o = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_op     <= '0;
            r_idx    <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_op  <= op_i;
                r_idx <= '0;
            end
            if (w_advance) r_idx <= r_idx + 8'd1;
            if (r_state == DONE) r_result <= w_acc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_base_a <= src_a_i;
            r_base_b <= src_b_i;
        end
        if (r_state == WAIT_A && mem_rvalid_i) r_act <= $signed(mem_rdata_i);
    end

    cnn_acc_unit u_acc (
        .clk_i  (clk_i),
        .i_op   (w_acc_op),
        .i_word ($signed(mem_rdata_i)),
        .i_act  (r_act),
        .o_acc  (w_acc)
    );

    // The final value is presented in the DONE cycle itself and held afterwards.
    assign result_o = (r_state == DONE) ? w_acc : r_result;

endmodule
